// File: rtl/buffet_sram_arbiter_if.sv
// Request, response and SRAM-side signals of the buffet SRAM arbiter.
// slave = arbiter view, master = requester/SRAM environment view.
interface buffet_sram_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_valid;
    logic                  rd_data_ready;
    logic [ADDR_WIDTH-1:0] addr_to_mem;
    logic [DATA_WIDTH-1:0] data_to_mem;
    logic                  wen_to_mem;
    logic                  ren_to_mem;
    logic [DATA_WIDTH-1:0] data_from_mem;

    modport slave (
        input  wr_addr, wr_data, wr_valid, rd_addr, rd_valid, rd_data_ready, data_from_mem,
        output wr_ready, rd_ready, rd_data, rd_data_valid,
               addr_to_mem, data_to_mem, wen_to_mem, ren_to_mem
    );

    modport master (
        output wr_addr, wr_data, wr_valid, rd_addr, rd_valid, rd_data_ready, data_from_mem,
        input  wr_ready, rd_ready, rd_data, rd_data_valid,
               addr_to_mem, data_to_mem, wen_to_mem, ren_to_mem
    );
endinterface

// File: rtl/buffet_sram_arbiter.sv
// Write/read arbiter for one single-port SRAM with a 2-entry read response FIFO.
// Optional macro BUFFET_ARB_PERF_EN adds saturating perf counters and an overflow assertion.
module buffet_sram_arbiter #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en_i,
    input  logic flush_i,
`ifdef BUFFET_ARB_PERF_EN
    output logic [31:0] perf_wr_grants_o,
    output logic [31:0] perf_rd_grants_o,
    output logic [31:0] perf_conflicts_o,
    buffet_sram_arbiter_if.slave bus
`else
    buffet_sram_arbiter_if.slave bus
`endif
);
    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  wptr_q;
    logic                  rptr_q;
    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  inflight_q;
    logic [CntW-1:0]       starve_q;
    logic [CntW-1:0]       starve_d;

    logic       active;
    logic       rd_vld;
    logic       pop;
    logic       push;
    logic       rd_elig;
    logic       wr_gnt;
    logic       rd_gnt;
    logic [2:0] occ_fut;

    // Grant decision: write wins unless a read has been passed over STARVE_LIMIT times.
    always_comb begin : grant_logic
        active  = rst_n && clk_en_i && !flush_i;
        rd_vld  = rst_n && (occ_q != 2'd0);
        pop     = rd_vld && bus.rd_data_ready && clk_en_i;
        push    = inflight_q;
        occ_fut = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        rd_elig = bus.rd_valid && (occ_fut < 3'd2);
        wr_gnt  = active && bus.wr_valid && !(rd_elig && (starve_q >= StarveMax));
        rd_gnt  = active && rd_elig && !wr_gnt;

        starve_d = starve_q;
        if (rd_gnt || !rd_elig) begin
            starve_d = '0;
        end else if (wr_gnt && (starve_q < StarveMax)) begin
            starve_d = starve_q + CntW'(1);
        end

        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    always_comb begin : mem_outputs
        bus.wr_ready      = wr_gnt;
        bus.wen_to_mem    = wr_gnt;
        bus.rd_ready      = rd_gnt;
        bus.ren_to_mem    = rd_gnt;
        bus.addr_to_mem   = ADDR_WIDTH'(0);
        bus.data_to_mem   = DATA_WIDTH'(0);
        if (wr_gnt) begin
            bus.addr_to_mem = bus.wr_addr;
            bus.data_to_mem = bus.wr_data;
        end else if (rd_gnt) begin
            bus.addr_to_mem = bus.rd_addr;
        end
        bus.rd_data       = fifo_q[rptr_q];
        bus.rd_data_valid = rd_vld;
    end

    // SRAM data for last cycle's read is captured on the next enabled edge.
    always_ff @(posedge clk) begin : state_regs
        if (!rst_n || flush_i) begin
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            starve_q   <= '0;
        end else if (clk_en_i) begin
            if (push) begin
                fifo_q[wptr_q] <= bus.data_from_mem;
            end
            wptr_q     <= wptr_q ^ push;
            rptr_q     <= rptr_q ^ pop;
            occ_q      <= occ_d;
            inflight_q <= rd_gnt;
            starve_q   <= starve_d;
        end
    end

`ifdef BUFFET_ARB_PERF_EN
    localparam int unsigned PerfW = 32;
    localparam logic [PerfW-1:0] PerfMax = '1;

    logic [PerfW-1:0] perf_wr_q;
    logic [PerfW-1:0] perf_rd_q;
    logic [PerfW-1:0] perf_cf_q;

    always_ff @(posedge clk) begin : perf_regs
        if (!rst_n || flush_i) begin
            perf_wr_q <= '0;
            perf_rd_q <= '0;
            perf_cf_q <= '0;
        end else if (clk_en_i) begin
            if (wr_gnt && (perf_wr_q != PerfMax)) perf_wr_q <= perf_wr_q + PerfW'(1);
            if (rd_gnt && (perf_rd_q != PerfMax)) perf_rd_q <= perf_rd_q + PerfW'(1);
            if (bus.wr_valid && bus.rd_valid && (perf_cf_q != PerfMax)) begin
                perf_cf_q <= perf_cf_q + PerfW'(1);
            end
        end
    end

    assign perf_wr_grants_o = perf_wr_q;
    assign perf_rd_grants_o = perf_rd_q;
    assign perf_conflicts_o = perf_cf_q;

    a_fifo_no_overflow : assert property (@(posedge clk) disable iff (!rst_n || flush_i)
        !(clk_en_i && push && (occ_q == 2'd2) && !pop));
`endif
endmodule

// File: tb/tb_buffet_sram_arbiter.sv
// Directed self-checking bench for buffet_sram_arbiter with a 1-cycle SRAM model.
module tb_buffet_sram_arbiter;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 9;

    logic clk;
    logic rst_n;
    logic clk_en;
    logic flush;
    int   checks;
    int   failures;

    buffet_sram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic [DW-1:0] sram [512];
    logic [DW-1:0] sram_dout;

`ifdef BUFFET_ARB_PERF_EN
    logic [31:0] perf_wr;
    logic [31:0] perf_rd;
    logic [31:0] perf_cf;
`endif

    buffet_sram_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clk_en_i        (clk_en),
        .flush_i         (flush),
`ifdef BUFFET_ARB_PERF_EN
        .perf_wr_grants_o(perf_wr),
        .perf_rd_grants_o(perf_rd),
        .perf_conflicts_o(perf_cf),
`endif
        .bus             (bus)
    );

    assign bus.data_from_mem = sram_dout;

    always @(posedge clk) begin
        if (clk_en) begin
            if (bus.wen_to_mem) sram[bus.addr_to_mem] <= bus.data_to_mem;
            if (bus.ren_to_mem) sram_dout <= sram[bus.addr_to_mem];
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid      = 1'b0;
        bus.rd_valid      = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_data       = '0;
        bus.rd_addr       = '0;
        bus.rd_data_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clk_en = 1'b1;
        flush = 1'b0;
        idle_inputs();
        bus.wr_valid = 1'b1;
        bus.rd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #2;
            checks++;
            if ({bus.wr_ready, bus.rd_ready, bus.wen_to_mem, bus.ren_to_mem, bus.rd_data_valid} !== 5'b0) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: wr_rdy=%b rd_rdy=%b wen=%b ren=%b rdv=%b required all 0",
                         i, bus.wr_ready, bus.rd_ready, bus.wen_to_mem, bus.ren_to_mem, bus.rd_data_valid);
            end
        end
        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            #2;
            checks++;
            if ({bus.wr_ready, bus.rd_ready, bus.wen_to_mem, bus.ren_to_mem, bus.rd_data_valid} !== 5'b0
                || bus.rd_data !== 64'd0 || bus.addr_to_mem !== 9'd0) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: wr_rdy=%b rd_rdy=%b wen=%b ren=%b rdv=%b rd_data=%h addr=%h required zeros",
                         i, bus.wr_ready, bus.rd_ready, bus.wen_to_mem, bus.ren_to_mem, bus.rd_data_valid,
                         bus.rd_data, bus.addr_to_mem);
            end
        end
    endtask

    task automatic test_write_read();
        cyc();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 9'h005;
        bus.wr_data  = 64'h00000000_DEADBEEF;
        #2;
        checks++;
        if (bus.wr_ready !== 1'b1 || bus.wen_to_mem !== 1'b1 || bus.ren_to_mem !== 1'b0
            || bus.addr_to_mem !== 9'h005 || bus.data_to_mem !== 64'h00000000_DEADBEEF) begin
            failures++;
            $display("FAIL wr_grant: wr_rdy=%b wen=%b ren=%b addr=%h data=%h required 1 1 0 005 deadbeef",
                     bus.wr_ready, bus.wen_to_mem, bus.ren_to_mem, bus.addr_to_mem, bus.data_to_mem);
        end
        cyc();
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 9'h005;
        #2;
        checks++;
        if (bus.rd_ready !== 1'b1 || bus.ren_to_mem !== 1'b1 || bus.wen_to_mem !== 1'b0
            || bus.addr_to_mem !== 9'h005 || bus.data_to_mem !== 64'd0) begin
            failures++;
            $display("FAIL rd_grant: rd_rdy=%b ren=%b wen=%b addr=%h data_to_mem=%h required 1 1 0 005 0",
                     bus.rd_ready, bus.ren_to_mem, bus.wen_to_mem, bus.addr_to_mem, bus.data_to_mem);
        end
        cyc();
        bus.rd_valid = 1'b0;
        #2;
        checks++;
        if (bus.rd_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_latency_early: rdv=%b required 0", bus.rd_data_valid);
        end
        cyc();
        #2;
        checks++;
        if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== 64'h00000000_DEADBEEF) begin
            failures++;
            $display("FAIL rd_after_wr: rdv=%b data=%h required 1 deadbeef", bus.rd_data_valid, bus.rd_data);
        end
        cyc();
        #2;
        checks++;
        if (bus.rd_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL rd_pop: rdv=%b required 0", bus.rd_data_valid);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 16; i++) begin
            cyc();
            bus.wr_valid = 1'b1;
            bus.wr_addr  = AW'(i);
            bus.wr_data  = DW'(i * 3);
            #2;
            checks++;
            if (bus.wr_ready !== 1'b1) begin
                failures++;
                $display("FAIL preload_wr%0d: wr_rdy=%b required 1", i, bus.wr_ready);
            end
        end
        for (int k = 0; k < 18; k++) begin
            cyc();
            bus.wr_valid = 1'b0;
            bus.rd_valid = (k < 16);
            bus.rd_addr  = AW'(k);
            #2;
            if (k < 16) begin
                checks++;
                if (bus.rd_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_rdy%0d: rd_rdy=%b required 1", k, bus.rd_ready);
                end
            end
            if (k >= 2) begin
                checks++;
                if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== DW'((k - 2) * 3)) begin
                    failures++;
                    $display("FAIL stream_resp%0d: rdv=%b data=%0d required 1 %0d",
                             k - 2, bus.rd_data_valid, bus.rd_data, (k - 2) * 3);
                end
            end
        end
        cyc();
        bus.rd_valid = 1'b0;
        #2;
        checks++;
        if (bus.rd_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_end: rdv=%b required 0", bus.rd_data_valid);
        end
    endtask

    task automatic test_starve();
        logic exp_rd;
        for (int k = 0; k < 15; k++) begin
            cyc();
            bus.wr_valid = 1'b1;
            bus.wr_addr  = AW'(200 + k);
            bus.wr_data  = DW'(k);
            bus.rd_valid = 1'b1;
            bus.rd_addr  = 9'd0;
            #2;
            exp_rd = ((k % 5) == 4);
            checks++;
            if (bus.wr_ready !== !exp_rd || bus.rd_ready !== exp_rd) begin
                failures++;
                $display("FAIL starve_pattern%0d: wr_rdy=%b rd_rdy=%b required %b %b",
                         k, bus.wr_ready, bus.rd_ready, !exp_rd, exp_rd);
            end
        end
        cyc();
        idle_inputs();
        cyc();
        cyc();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int got = 0;
        idle_inputs();
        bus.rd_data_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            bus.rd_valid = 1'b1;
            bus.rd_addr  = AW'(1 + acc);
            #2;
            if (k == 5) begin
                checks++;
                if (bus.rd_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_full_rdy: rd_rdy=%b required 0", bus.rd_ready);
                end
            end
            if (bus.rd_ready === 1'b1) acc++;
        end
        checks++;
        if (acc != 2) begin
            failures++;
            $display("FAIL bp_accepted: accepted=%0d required 2", acc);
        end
        checks++;
        if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== 64'd3) begin
            failures++;
            $display("FAIL bp_head: rdv=%b data=%0d required 1 3", bus.rd_data_valid, bus.rd_data);
        end
        for (int k = 0; k < 30 && got < 5; k++) begin
            cyc();
            bus.rd_data_ready = 1'b1;
            bus.rd_valid      = (acc < 5);
            bus.rd_addr       = AW'(1 + acc);
            #2;
            if (bus.rd_data_valid === 1'b1) begin
                checks++;
                if (bus.rd_data !== DW'((got + 1) * 3)) begin
                    failures++;
                    $display("FAIL bp_order%0d: data=%0d required %0d", got, bus.rd_data, (got + 1) * 3);
                end
                got++;
            end
            if (bus.rd_ready === 1'b1) acc++;
        end
        checks++;
        if (got != 5) begin
            failures++;
            $display("FAIL bp_drain_timeout: responses=%0d required 5", got);
        end
        cyc();
        idle_inputs();
    endtask

    task automatic test_clk_en_flush();
        idle_inputs();
        cyc();
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 9'd6;
        #2;
        checks++;
        if (bus.rd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cken_issue: rd_rdy=%b required 1", bus.rd_ready);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            clk_en       = 1'b0;
            bus.rd_addr  = 9'd7;
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 9'd300;
            #2;
            checks++;
            if ({bus.wr_ready, bus.rd_ready, bus.wen_to_mem, bus.ren_to_mem, bus.rd_data_valid} !== 5'b0) begin
                failures++;
                $display("FAIL cken_low%0d: wr_rdy=%b rd_rdy=%b wen=%b ren=%b rdv=%b required all 0",
                         k, bus.wr_ready, bus.rd_ready, bus.wen_to_mem, bus.ren_to_mem, bus.rd_data_valid);
            end
        end
        cyc();
        clk_en = 1'b1;
        idle_inputs();
        #2;
        checks++;
        if (bus.rd_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL cken_capture_early: rdv=%b required 0", bus.rd_data_valid);
        end
        cyc();
        #2;
        checks++;
        if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== 64'd18) begin
            failures++;
            $display("FAIL cken_resp: rdv=%b data=%0d required 1 18", bus.rd_data_valid, bus.rd_data);
        end

        // Fill the FIFO with two responses, then flush them away.
        cyc();
        bus.rd_data_ready = 1'b0;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 9'd7;
        #2;
        cyc();
        bus.rd_addr = 9'd8;
        #2;
        cyc();
        bus.rd_valid = 1'b0;
        #2;
        cyc();
        #2;
        checks++;
        if (bus.rd_data_valid !== 1'b1 || bus.rd_data !== 64'd21) begin
            failures++;
            $display("FAIL flush_prefill: rdv=%b data=%0d required 1 21", bus.rd_data_valid, bus.rd_data);
        end
        cyc();
        flush = 1'b1;
        #2;
        cyc();
        flush = 1'b0;
        #2;
        checks++;
        if (bus.rd_data_valid !== 1'b0 || bus.rd_data !== 64'd0) begin
            failures++;
            $display("FAIL flush_clear: rdv=%b data=%h required 0 0", bus.rd_data_valid, bus.rd_data);
        end
        cyc();
        bus.rd_data_ready = 1'b1;
        #2;

        // Build up the starve count, flush, and confirm the full write run restarts.
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.wr_valid = 1'b1;
            bus.wr_addr  = AW'(400 + k);
            bus.rd_valid = 1'b1;
            bus.rd_addr  = 9'd0;
            #2;
            checks++;
            if (bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b0) begin
                failures++;
                $display("FAIL flush_prestarve%0d: wr_rdy=%b rd_rdy=%b required 1 0", k, bus.wr_ready, bus.rd_ready);
            end
        end
        cyc();
        flush = 1'b1;
        #2;
        for (int k = 0; k < 5; k++) begin
            cyc();
            flush = 1'b0;
            #2;
            checks++;
            if (bus.wr_ready !== (k != 4) || bus.rd_ready !== (k == 4)) begin
                failures++;
                $display("FAIL flush_starve_clr%0d: wr_rdy=%b rd_rdy=%b required %b %b",
                         k, bus.wr_ready, bus.rd_ready, (k != 4), (k == 4));
            end
        end
        cyc();
        idle_inputs();
        cyc();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_stream();
        test_starve();
        test_backpressure();
        test_clk_en_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/buffet_sram_arbiter.md
Name: buffet_sram_arbiter

Overview:
- Shares one single-port SRAM macro (sram_sp: 64-bit data, 9-bit address, 1-cycle read latency) between a write requester and a read requester.
- Typical write requester is the write scanner path; typical read requester is the read scanner path.
- Issues at most one memory operation per cycle and buffers read responses in a 2-entry response FIFO, so read data is never lost under downstream backpressure.
- Sits between the buffet request logic and the SRAM.

Parameters:
- DATA_WIDTH, 64, SRAM word width.
- ADDR_WIDTH, 9, SRAM address width.
- STARVE_LIMIT, 4, maximum consecutive write grants while an eligible read waits; range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- clk_en  in  1  global clock enable; 0 freezes all state.
- flush  in  1  synchronous clear, same effect as reset.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted this cycle.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_data  out  DATA_WIDTH  read response data (response FIFO head).
- rd_data_valid  out  1  response FIFO non-empty.
- rd_data_ready  in  1  consumer pops the response.
- addr_to_mem  out  ADDR_WIDTH  SRAM address.
- data_to_mem  out  DATA_WIDTH  SRAM write data.
- wen_to_mem  out  1  SRAM write enable.
- ren_to_mem  out  1  SRAM read enable.
- data_from_mem  in  DATA_WIDTH  SRAM read data, valid 1 cycle after ren_to_mem.

Behaviour:
- Reset and flush: rst_n=0 or flush=1 at a clk edge clears the response FIFO, inflight flag and starve counter.
  - While rst_n=0: wr_ready, rd_ready, wen_to_mem, ren_to_mem and rd_data_valid are all 0.
  - rd_data and addr_to_mem read 0 from cleared state.
- Read eligibility: rd_elig = rd_valid and (occ + inflight - pop) < 2.
  - occ: FIFO entries, 0..2.
  - inflight: 1 if ren_to_mem was asserted last cycle.
  - pop: rd_data_valid and rd_data_ready.
- Grant (combinational, one per cycle):
  - Both wr_valid and rd_elig, starve_cnt < STARVE_LIMIT: grant write.
  - Both wr_valid and rd_elig, starve_cnt == STARVE_LIMIT: grant read.
  - Otherwise grant whichever one is requesting; neither requesting means idle.
- starve_cnt (4 bits):
  - Increments on a write grant while rd_elig=1.
  - Clears on any read grant, or any cycle with rd_elig=0.
  - Saturates at STARVE_LIMIT.
- Write grant: wr_ready=1, wen_to_mem=1, addr_to_mem=wr_addr, data_to_mem=wr_data. Acceptance is the same cycle (wr_ready depends on wr_valid).
- Read grant: rd_ready=1, ren_to_mem=1, addr_to_mem=rd_addr; inflight is set next cycle. When no write is granted, data_to_mem=0.
- Response path:
  - The cycle after a read grant, data_from_mem is pushed into the FIFO at that cycle's edge.
  - Push and pop may occur in the same cycle; occupancy is unchanged.
  - Latency from rd_valid&rd_ready to rd_data_valid: 2 cycles.
  - Sustained throughput: 1 read per cycle with rd_data_ready held at 1.
- FIFO full boundary: occ=2, or occ=1 with inflight=1 and no pop, gives rd_elig=0. The occupancy/inflight rule above guarantees no overflow; overflow is an error that the assertion (optional feature) checks.
- clk_en=0:
  - All registers hold.
  - wr_ready, rd_ready, wen_to_mem, ren_to_mem forced 0.
  - rd_data_valid still reflects FIFO state, but pop is suppressed.
  - A read issued before clk_en fell is captured on the first enabled edge; the SRAM output is held by the same clk_en.
- Ordering:
  - Write then read of the same address on consecutive cycles returns the new data.
  - Read responses return in issue order.
- Reset or flush mid-read discards the in-flight read and all buffered responses.

Optional Feature:
- Macro: BUFFET_ARB_PERF_EN.
- When defined, adds three 32-bit outputs, each cleared by reset/flush, counting only when clk_en=1 and saturating at 0xFFFFFFFF:
  - perf_wr_grants: counts write grants.
  - perf_rd_grants: counts read grants.
  - perf_conflicts: counts cycles with wr_valid and rd_valid both 1.
- Also adds a simulation assertion that a FIFO push never occurs when occ=2 without a same-cycle pop.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n=0 for 3 cycles, then release with no requests.
  - Required: all enables/readies 0, rd_data_valid=0 for 10 cycles.
- Write/read same address:
  - Stimulus: write 0x00000000_DEADBEEF to addr 0x05, then read addr 0x05, rd_data_ready=1.
  - Required: rd_data_valid rises exactly 2 cycles after the read handshake with rd_data=0x00000000_DEADBEEF.
- Read streaming:
  - Stimulus: 16 back-to-back reads of addr 0..15 (preloaded data=addr*3), rd_data_ready=1.
  - Required: rd_ready=1 every cycle, 16 responses 0,3,...,45 on consecutive cycles.
- Starvation bound:
  - Stimulus: wr_valid=1 continuously, rd_valid=1 continuously, STARVE_LIMIT=4.
  - Required: grant pattern W,W,W,W,R repeating; no read waits more than 4 cycles.
- Backpressure:
  - Stimulus: rd_data_ready=0, 5 reads requested.
  - Required: exactly 2 accepted, rd_ready=0 afterwards, FIFO holds the 2 in order.
  - Then: raising rd_data_ready drains them and the remaining 3 complete in order.
- clk_en and flush:
  - Stimulus: drop clk_en for 4 cycles with one read in flight.
  - Required: no new grants while low; the response appears after re-enable.
  - Then: flush with 2 buffered responses.
  - Required: rd_data_valid=0 the next cycle, starve_cnt=0.
